// File: rtl/cim_xbar_tile_model.sv
// ---------------------------------------------------------------------------
// cim_xbar_tile_model
// Cycle-accurate behavioural model of one CIM crossbar tile, responder on the
// fc_layer CIM port. Holds an input vector buffer and a 1-bit weight array,
// computes a matrix-vector product one row per cycle (all columns in
// parallel), then quantises each column sum into a result register that can
// be read back by column address with one cycle of latency.
//
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   i_we, i_wr_addr, i_wr_data     input-buffer write (IDLE only)
//   i_w_we, i_w_row, i_w_col,
//   i_w_bit                        weight-cell write (IDLE only)
//   i_start                        start MVM (single-cycle pulse, IDLE only)
//   o_busy                         high from start until the DONE cycle ends
//   o_done                         one-cycle pulse, results latched this cycle
//   i_rd_addr, o_data              registered result read, 1-cycle latency
// ---------------------------------------------------------------------------
module cim_xbar_tile_model #(
    parameter int xbar_size     = 256,
    parameter int datatype_size = 4,
    parameter int adc_shift     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_w_we,
    input  logic [$clog2(xbar_size)-1:0] i_w_row,
    input  logic [$clog2(xbar_size)-1:0] i_w_col,
    input  logic                         i_w_bit,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_data
);

    localparam int AW    = $clog2(xbar_size);
    // Wide enough for xbar_size * (2**datatype_size - 1) without overflow.
    localparam int ACC_W = datatype_size + AW;
    localparam logic [ACC_W-1:0] SAT = ACC_W'((1 << datatype_size) - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [AW-1:0]            row;
    logic [datatype_size-1:0] ibuf [xbar_size];
    logic [xbar_size-1:0]     w    [xbar_size];
    logic [ACC_W-1:0]         acc  [xbar_size];
    logic [datatype_size-1:0] res  [xbar_size];

    logic [xbar_size-1:0]     row_w;
    logic [ACC_W-1:0]         row_in;

    function automatic logic [datatype_size-1:0] quantise(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> adc_shift;
        if (s > SAT) begin
            return '1;
        end
        return s[datatype_size-1:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = COMPUTE;
            COMPUTE: if (row == AW'(xbar_size - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy spans COMPUTE and DONE; done marks the single DONE cycle.
    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    // ---------------- storage (not cleared by reset) ----------------
    // Writes issued alongside i_start land on the same edge, so row 0 sees them.
    always_ff @(posedge clk) begin
        if (state == IDLE && i_we) begin
            ibuf[i_wr_addr] <= i_wr_data;
        end
        if (state == IDLE && i_w_we) begin
            w[i_w_row][i_w_col] <= i_w_bit;
        end
    end

    always_comb begin
        row_w  = w[row];
        row_in = ACC_W'(ibuf[row]);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            row    <= '0;
            o_data <= '0;
            for (int unsigned c = 0; c < xbar_size; c++) begin
                acc[c] <= '0;
                res[c] <= '0;
            end
        end else begin
            o_data <= res[i_rd_addr];
            case (state)
                IDLE: begin
                    if (i_start) begin
                        row <= '0;
                        for (int unsigned c = 0; c < xbar_size; c++) begin
                            acc[c] <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    for (int unsigned c = 0; c < xbar_size; c++) begin
                        if (row_w[c]) begin
                            acc[c] <= acc[c] + row_in;
                        end
                    end
                    row <= row + AW'(1);
                end
                DONE: begin
                    for (int unsigned c = 0; c < xbar_size; c++) begin
                        res[c] <= quantise(acc[c]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_xbar_tile_model.sv
module tb_cim_xbar_tile_model;

    localparam int XS = 256;
    localparam int DW = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_we;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_w_we;
    logic [AW-1:0] i_w_row;
    logic [AW-1:0] i_w_col;
    logic          i_w_bit;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] o_data;

    always #5 clk = ~clk;

    cim_xbar_tile_model #(
        .xbar_size    (XS),
        .datatype_size(DW),
        .adc_shift    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_we     (i_we),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .i_w_we   (i_w_we),
        .i_w_row  (i_w_row),
        .i_w_col  (i_w_col),
        .i_w_bit  (i_w_bit),
        .i_start  (i_start),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .i_rd_addr(i_rd_addr),
        .o_data   (o_data)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard of expected read data, pushed when a read is issued.
    int    exp_q[$];
    string tag_q[$];

    // Reference model: full input buffer, weights for columns 0..3 only.
    bit [DW-1:0] m_ibuf [XS];
    bit [3:0]    m_w    [XS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int model_col(input int c);
        int s;
        s = 0;
        for (int r = 0; r < XS; r++) begin
            if (m_w[r][c]) s += int'(m_ibuf[r]);
        end
        s = s >> 4;
        return (s > 15) ? 15 : s;
    endfunction

    task automatic sb_pop_check();
        int    e;
        string t;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(o_data), 32'(e));
        end
    endtask

    task automatic read_col(input int a, input int exp, input string pfx);
        exp_q.push_back(exp);
        tag_q.push_back($sformatf("%s_col%0d", pfx, a));
        i_rd_addr = AW'(a);
        tick();
        sb_pop_check();
    endtask

    task automatic wr_in(input int a, input int d);
        i_we      = 1'b1;
        i_wr_addr = AW'(a);
        i_wr_data = DW'(d);
        tick();
        i_we = 1'b0;
        m_ibuf[a] = DW'(d);
    endtask

    task automatic wr_w(input int r, input int c, input bit b);
        i_w_we  = 1'b1;
        i_w_row = AW'(r);
        i_w_col = AW'(c);
        i_w_bit = b;
        tick();
        i_w_we = 1'b0;
        if (c < 4) m_w[r][c] = b;
    endtask

    // Iteration k drives the inputs sampled at edge k (start at edge 0), then
    // observes outputs of cycle k+1. Fixed length, so it always terminates.
    task automatic run(input int wr_at, input int rd_at, input int rd_exp,
                       input int restart_at, input int rst_at, input bit co_we,
                       output int busy_n, output int done_n, output int first_done);
        busy_n     = 0;
        done_n     = 0;
        first_done = -1;
        for (int k = 0; k <= 265; k++) begin
            i_start = (k == 0) || (k == restart_at);
            rst     = (k == rst_at) ? 1'b0 : 1'b1;
            i_we    = 1'b0;
            i_w_we  = 1'b0;
            if (k == wr_at) begin
                i_we      = 1'b1;
                i_wr_addr = AW'(100);
                i_wr_data = DW'(15);
                i_w_we    = 1'b1;
                i_w_row   = AW'(100);
                i_w_col   = AW'(2);
                i_w_bit   = 1'b1;
            end
            if (co_we && k == 0) begin
                i_we      = 1'b1;
                i_wr_addr = AW'(0);
                i_wr_data = DW'(0);
            end
            if (k == rd_at) begin
                i_rd_addr = AW'(2);
                exp_q.push_back(rd_exp);
                tag_q.push_back("rd_during_compute");
            end
            tick();
            i_start = 1'b0;
            i_we    = 1'b0;
            i_w_we  = 1'b0;
            rst     = 1'b1;
            if (o_busy === 1'b1) busy_n++;
            if (o_done === 1'b1) begin
                done_n++;
                if (first_done < 0) first_done = k + 1;
            end
            if (k == rd_at) sb_pop_check();
        end
    endtask

    int busy_n, done_n, first_done, old2;

    initial begin
        rst = 1'b0; i_we = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        i_w_we = 1'b0; i_w_row = '0; i_w_col = '0; i_w_bit = 1'b0;
        i_start = 1'b0; i_rd_addr = '0;

        // Reset, then idle.
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        read_col(0, 0, "rst");
        read_col(1, 0, "rst");
        read_col(2, 0, "rst");
        read_col(255, 0, "rst");

        // ibuf all 1; column 0 all ones; column 1 only row 0.
        for (int r = 0; r < XS; r++) wr_in(r, 1);
        for (int r = 0; r < XS; r++)
            for (int c = 0; c < 4; c++) wr_w(r, c, 1'b0);
        for (int r = 0; r < XS; r++) wr_w(r, 0, 1'b1);
        wr_w(0, 1, 1'b1);
        run(-1, -1, 0, -1, -1, 1'b0, busy_n, done_n, first_done);
        check("run1_busy_cycles", 32'(busy_n), 32'd257);
        check("run1_done_count", 32'(done_n), 32'd1);
        check("run1_done_cycle", 32'(first_done), 32'd257);
        check("run1_col0_model", 32'(model_col(0)), 32'd15);
        for (int c = 0; c < 4; c++) read_col(c, model_col(c), "run1");

        // Eight rows of 15 into column 2; mid-run writes must be ignored,
        // and a read mid-run returns the previous column 2 result.
        old2 = model_col(2);
        for (int r = 0; r < 8; r++) begin
            wr_in(r, 15);
            wr_w(r, 2, 1'b1);
        end
        run(20, 30, old2, -1, -1, 1'b0, busy_n, done_n, first_done);
        check("run2_busy_cycles", 32'(busy_n), 32'd257);
        check("run2_done_cycle", 32'(first_done), 32'd257);
        read_col(2, 7, "run2");
        for (int c = 0; c < 4; c++) read_col(c, model_col(c), "run2");

        // Same stimulus again, with a stray start mid-run.
        run(-1, -1, 0, 100, -1, 1'b0, busy_n, done_n, first_done);
        check("run3_busy_cycles", 32'(busy_n), 32'd257);
        check("run3_done_count", 32'(done_n), 32'd1);
        check("run3_done_cycle", 32'(first_done), 32'd257);
        for (int c = 0; c < 4; c++) read_col(c, model_col(c), "run3");

        // Reset at cycle 50 aborts the run and clears results.
        run(-1, -1, 0, -1, 50, 1'b0, busy_n, done_n, first_done);
        check("abort_busy_cycles", 32'(busy_n), 32'd50);
        check("abort_done_count", 32'(done_n), 32'd0);
        for (int c = 0; c < 4; c++) read_col(c, 0, "abort");

        // Restart with retained state; ibuf[0]<=0 written together with start.
        m_ibuf[0] = '0;
        run(-1, -1, 0, -1, -1, 1'b1, busy_n, done_n, first_done);
        check("run4_busy_cycles", 32'(busy_n), 32'd257);
        check("run4_done_cycle", 32'(first_done), 32'd257);
        read_col(2, 6, "run4");
        for (int c = 0; c < 4; c++) read_col(c, model_col(c), "run4");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
